// File: rtl/pcie_pwr_seq_pkg.sv
// Shared types and default timing for the PCIe power sequencer.
package pcie_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWR_WAIT,
    ST_RAIL_DLY,
    ST_CLK_DLY,
    ST_PERST_DLY,
    ST_ACTIVE,
    ST_SHUTDOWN,
    ST_FAULT
  } seq_state_t;

  // Default timing, in cycles of the 100 MHz sequencer clock
  localparam int unsigned DEF_T_PGOOD_TO_CYC   = 1_000_000;
  localparam int unsigned DEF_T_RAIL_GRST_CYC  = 1_000;
  localparam int unsigned DEF_T_GRST_CLK_CYC   = 1_000;
  localparam int unsigned DEF_T_GRST_PERST_CYC = 10_000_000;
  localparam int unsigned DEF_T_CLK_PERST_CYC  = 10_000;
  localparam int unsigned DEF_T_SD_STEP_CYC    = 100;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcie_seq_timer.sv
// Loadable saturating up-counter with a ">= limit" done flag.
module pcie_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // Count up from the loaded value, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '1) begin
      count <= count + W'(1);
    end
  end

  assign done = (count >= limit);

endmodule

// File: rtl/pcie_power_sequencer.sv
// PCIe slot power-up / power-down sequencer: rails, global reset, refclk, PERST#.
module pcie_power_sequencer
  import pcie_pwr_seq_pkg::*;
#(
  parameter int unsigned T_PGOOD_TO_CYC   = DEF_T_PGOOD_TO_CYC,
  parameter int unsigned T_RAIL_GRST_CYC  = DEF_T_RAIL_GRST_CYC,
  parameter int unsigned T_GRST_CLK_CYC   = DEF_T_GRST_CLK_CYC,
  parameter int unsigned T_GRST_PERST_CYC = DEF_T_GRST_PERST_CYC,
  parameter int unsigned T_CLK_PERST_CYC  = DEF_T_CLK_PERST_CYC,
  parameter int unsigned T_SD_STEP_CYC    = DEF_T_SD_STEP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic pgood_1v5,
  input  logic pgood_3v3,
  output logic vdd_1v5_en,
  output logic vdd_3v3_en,
  output logic grst_n,
  output logic ref_clk_en,
  output logic perst_n,
  output logic seq_done,
  output logic seq_fault
);

  localparam int unsigned MAX_T = max_u(max_u(max_u(T_PGOOD_TO_CYC, T_RAIL_GRST_CYC),
                                              max_u(T_GRST_CLK_CYC, T_GRST_PERST_CYC)),
                                        max_u(T_CLK_PERST_CYC, T_SD_STEP_CYC));
  // One spare bit keeps the power-good timeout limit (T + 1) representable
  localparam int W = $clog2(MAX_T + 1) + 1;

  localparam logic [W-1:0] LIM_PG    = W'(T_PGOOD_TO_CYC + 1);
  localparam logic [W-1:0] LIM_RAIL  = W'(T_RAIL_GRST_CYC);
  localparam logic [W-1:0] LIM_GC    = W'(T_GRST_CLK_CYC);
  localparam logic [W-1:0] LIM_GP    = W'(T_GRST_PERST_CYC);
  localparam logic [W-1:0] LIM_CP    = W'(T_CLK_PERST_CYC);
  localparam logic [W-1:0] LIM_SD    = W'(T_SD_STEP_CYC);
  // Timers read k at the k-th edge after the loading edge
  localparam logic [W-1:0] LOAD_ONE  = W'(1);
  // PERST# may release on the refclk edge itself when no refclk wait applies
  // and the grst-to-perst wait is already covered by the grst-to-clk wait
  localparam bit PERST_WITH_CLK = (T_CLK_PERST_CYC == 0) && (T_GRST_PERST_CYC <= T_GRST_CLK_CYC);

  seq_state_t   state;
  logic         sd_step2;
  logic         pg15_q, pg33_q;
  logic         pg_both, pg_fall, rails_on;
  logic         fault_evt, stop_evt, adv;
  logic         load_a, load_b, a_done, b_done;
  logic [W-1:0] lim_a;

  assign pg_both  = pgood_1v5 & pgood_3v3;
  assign rails_on = vdd_1v5_en | vdd_3v3_en;

  // Timer A: power-good timeout, rail delay, time since grst_n rise, shutdown steps
  pcie_seq_timer #(.W(W)) u_tmr_grst (
    .clk      (clk),
    .rst      (rst),
    .load     (load_a),
    .load_val (LOAD_ONE),
    .limit    (lim_a),
    .done     (a_done)
  );

  // Timer B: time since ref_clk_en rise
  pcie_seq_timer #(.W(W)) u_tmr_clk (
    .clk      (clk),
    .rst      (rst),
    .load     (load_b),
    .load_val (LOAD_ONE),
    .limit    (LIM_CP),
    .done     (b_done)
  );

  // Decode this cycle's fault, stop and advance events plus timer loads
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pg_fall   = (pg15_q & ~pgood_1v5) | (pg33_q & ~pgood_3v3);
    fault_evt = 1'b0;
    stop_evt  = 1'b0;
    adv       = 1'b0;
    lim_a     = '0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    case (state)
      ST_OFF:       adv = start;
      ST_PWR_WAIT: begin
        lim_a     = LIM_PG;
        adv       = pg_both;
        fault_evt = a_done & ~pg_both;
        stop_evt  = stop;
      end
      ST_RAIL_DLY: begin
        lim_a     = LIM_RAIL;
        adv       = a_done;
        fault_evt = rails_on & pg_fall;
        stop_evt  = stop;
      end
      ST_CLK_DLY: begin
        lim_a     = LIM_GC;
        adv       = a_done;
        fault_evt = rails_on & pg_fall;
        stop_evt  = stop;
      end
      ST_PERST_DLY: begin
        lim_a     = LIM_GP;
        adv       = a_done & b_done;
        fault_evt = rails_on & pg_fall;
        stop_evt  = stop;
      end
      ST_ACTIVE: begin
        fault_evt = rails_on & pg_fall;
        stop_evt  = stop;
      end
      ST_SHUTDOWN: begin
        lim_a     = LIM_SD;
        adv       = a_done;
        fault_evt = rails_on & pg_fall;
      end
      default: ;
    endcase
    if (!fault_evt) begin
      if (stop_evt) begin
        load_a = 1'b1;
      end else if (adv) begin
        case (state)
          ST_OFF, ST_PWR_WAIT, ST_RAIL_DLY: load_a = 1'b1;
          ST_CLK_DLY:                       load_b = 1'b1;
          ST_SHUTDOWN:                      load_a = ~sd_step2;
          default: ;
        endcase
      end
    end
  end

  // Sequencer state and registered outputs; fault beats stop beats progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OFF;
      sd_step2   <= 1'b0;
      pg15_q     <= 1'b0;
      pg33_q     <= 1'b0;
      vdd_1v5_en <= 1'b0;
      vdd_3v3_en <= 1'b0;
      grst_n     <= 1'b0;
      ref_clk_en <= 1'b0;
      perst_n    <= 1'b0;
      seq_done   <= 1'b0;
      seq_fault  <= 1'b0;
    end else begin
      pg15_q <= pgood_1v5;
      pg33_q <= pgood_3v3;
      if (fault_evt) begin
        state      <= ST_FAULT;
        vdd_1v5_en <= 1'b0;
        vdd_3v3_en <= 1'b0;
        grst_n     <= 1'b0;
        ref_clk_en <= 1'b0;
        perst_n    <= 1'b0;
        seq_done   <= 1'b0;
        seq_fault  <= 1'b1;
      end else if (stop_evt) begin
        state    <= ST_SHUTDOWN;
        perst_n  <= 1'b0;
        seq_done <= 1'b0;
        sd_step2 <= 1'b0;
      end else begin
        case (state)
          ST_OFF: if (start) begin
            state      <= ST_PWR_WAIT;
            vdd_1v5_en <= 1'b1;
            vdd_3v3_en <= 1'b1;
          end
          ST_PWR_WAIT: if (pg_both) state <= ST_RAIL_DLY;
          ST_RAIL_DLY: if (a_done) begin
            grst_n <= 1'b1;
            state  <= ST_CLK_DLY;
          end
          ST_CLK_DLY: if (a_done) begin
            ref_clk_en <= 1'b1;
            if (PERST_WITH_CLK) begin
              perst_n  <= 1'b1;
              seq_done <= 1'b1;
              state    <= ST_ACTIVE;
            end else begin
              state <= ST_PERST_DLY;
            end
          end
          ST_PERST_DLY: if (a_done && b_done) begin
            perst_n  <= 1'b1;
            seq_done <= 1'b1;
            state    <= ST_ACTIVE;
          end
          ST_ACTIVE: ;
          ST_SHUTDOWN: if (a_done) begin
            if (!sd_step2) begin
              ref_clk_en <= 1'b0;
              grst_n     <= 1'b0;
              sd_step2   <= 1'b1;
            end else begin
              vdd_1v5_en <= 1'b0;
              vdd_3v3_en <= 1'b0;
              state      <= ST_OFF;
            end
          end
          ST_FAULT: if (stop && !start) begin
            seq_fault <= 1'b0;
            state     <= ST_OFF;
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule

// File: doc/pcie_power_sequencer.md
PCIE_POWER_SEQUENCER -- requirements
Module: pcie_power_sequencer

Interface
REQ-001 Parameter T_PGOOD_TO_CYC, default 1_000_000; max cycles to wait for both power-goods after rail enable.
REQ-002 Parameter T_RAIL_GRST_CYC, default 1_000; cycles from both power-goods high to grst_n deassert.
REQ-003 Parameter T_GRST_CLK_CYC, default 1_000; cycles from grst_n deassert to ref_clk_en assert.
REQ-004 Parameter T_GRST_PERST_CYC, default 10_000_000; minimum cycles from grst_n deassert to perst_n deassert (100 ms at 100 MHz).
REQ-005 Parameter T_CLK_PERST_CYC, default 10_000; minimum cycles from ref_clk_en assert to perst_n deassert (100 us at 100 MHz).
REQ-006 Parameter T_SD_STEP_CYC, default 100; cycles per shutdown step.
REQ-007 clk  input  1  free-running always-on sequencer clock; one clock, all logic on posedge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  power-up request, level, sampled only in OFF.
REQ-010 stop  input  1  power-down request, level.
REQ-011 pgood_1v5, pgood_3v3  input  1 each  rail power-good, synchronous to clk.
REQ-012 vdd_1v5_en, vdd_3v3_en  output  1 each  rail enables.
REQ-013 grst_n, ref_clk_en, perst_n  output  1 each  global reset (low = reset), reference-clock enable, PCIe PERST# (low = reset).
REQ-014 seq_done  output  1  high only in ACTIVE; seq_fault  output  1  high only in FAULT.

Function
REQ-015 States: OFF, PWR_WAIT, RAIL_DLY, CLK_DLY, PERST_DLY, ACTIVE, SHUTDOWN, FAULT; all outputs registered, one transition per cycle max.
REQ-016 OFF: all outputs 0 except none; start=1 at edge k -> rails enabled after edge k, state PWR_WAIT.
REQ-017 PWR_WAIT: both pgood high -> RAIL_DLY; T_PGOOD_TO_CYC elapsed without both -> FAULT.
REQ-018 RAIL_DLY: after T_RAIL_GRST_CYC cycles grst_n=1, -> CLK_DLY.
REQ-019 CLK_DLY: after T_GRST_CLK_CYC cycles ref_clk_en=1, -> PERST_DLY.
REQ-020 If grst_n rises at edge e, perst_n shall rise at edge e + max(T_GRST_PERST_CYC, T_GRST_CLK_CYC + T_CLK_PERST_CYC), never earlier; then ACTIVE.
REQ-021 Two independent counters (since-grst, since-refclk), width $clog2 of largest parameter +1, saturating, never wrapping.
REQ-022 stop=1 in any state after OFF and before FAULT -> SHUTDOWN; start ignored outside OFF.
REQ-023 SHUTDOWN: entry edge perst_n=0; +T_SD_STEP_CYC ref_clk_en=0 and grst_n=0; +2*T_SD_STEP_CYC rails off, -> OFF.
REQ-024 Either pgood falling while rails enabled outside PWR_WAIT -> FAULT; all outputs drop to 0 the same edge (perst_n, grst_n, ref_clk_en, rails).
REQ-025 Same-cycle pgood loss and stop: FAULT wins.
REQ-026 FAULT held until stop=1 and start=0, then OFF.
REQ-027 Parameter T_CLK_PERST_CYC or T_GRST_PERST_CYC of 0 imposes no wait from that term.

Reset
REQ-028 rst=1: state OFF, all outputs 0 (perst_n=0, grst_n=0), counters 0, immediately without clock.
REQ-029 rst mid-sequence aborts without shutdown ordering; after release the block waits in OFF for start.

Structure
REQ-030 Package pcie_pwr_seq_pkg: state enum, default timing constants.
REQ-031 One sub-module pcie_seq_timer: loadable saturating counter with done flag, instantiated twice.

Verification
REQ-032 Params RAIL=4, GRST_CLK=5, GRST_PERST=20, CLK_PERST=8; start, pgoods high 3 cycles later -> grst_n at +4, ref_clk_en at grst+5, perst_n at grst+20, seq_done.
REQ-033 Same but CLK_PERST=30 -> perst_n at grst+35.
REQ-034 pgood_3v3 never rises, PGOOD_TO=50 -> seq_fault at cycle 51 after rails on, all outputs 0.
REQ-035 stop in ACTIVE, SD_STEP=3 -> perst_n low next edge, ref_clk_en/grst_n low +3, rails off +6, OFF.
REQ-036 pgood_1v5 drop and stop same cycle in PERST_DLY -> FAULT, perst_n never rose.
REQ-037 rst pulsed in CLK_DLY -> outputs 0 asynchronously; new start repeats full timing.
